// File: rtl/load_store_unit.sv
// load_store_unit: memory-stage load/store controller for a word-addressed,
// write-enable-only data memory. Byte and halfword loads are extended, and
// byte and halfword stores use read-modify-write. Misaligned or illegal
// requests are answered at once and never touch memory.
//
// Handshake: a request transfers on a rising edge when req_valid=1 and
// req_ready=1. req_ready is high only in IDLE, so request inputs are ignored
// in every other state. The response is a single-cycle resp_valid pulse with
// no back-pressure, and resp_rdata/resp_misaligned/resp_illegal are zero
// whenever resp_valid=0.
module load_store_unit #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_read,
  input  logic                  req_write,
  input  logic [2:0]            req_funct3,
  input  logic [31:0]           req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  resp_valid,
  output logic [31:0]           resp_rdata,
  output logic                  resp_misaligned,
  output logic                  resp_illegal,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_we,
  output logic [31:0]           mem_wdata,
  input  logic [31:0]           mem_rdata,
  output logic [2:0]            dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_RMW_RD = 3'd2,
    S_WRITE  = 3'd3,
    S_RESP   = 3'd4
  } state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   widx_q, widx_d;
  logic [1:0]              lane_q, lane_d;
  logic [2:0]              funct3_q, funct3_d;
  logic [31:0]             wdata_q, wdata_d;
  logic                    write_q, write_d;
  logic                    illegal_q, illegal_d;
  logic                    misaligned_q, misaligned_d;
  // Holds the extended load result, or the old word during a sub-word store.
  logic [31:0]             word_q, word_d;

  logic                    legal_load;
  logic                    legal_store;
  logic                    req_illegal;
  logic                    req_misaligned;
  logic [7:0]              load_byte;
  logic [15:0]             load_half;
  logic [31:0]             load_ext;
  logic [31:0]             merged;
  logic                    ready_int;

  // Address bits above the memory's word index are deliberately dropped.
  logic                    unused_addr_bits;
  assign unused_addr_bits = ^req_addr[31:ADDR_WIDTH+2];

  // Classify the incoming request; illegal masks misaligned.
  always_comb begin
    legal_load     = 1'b0;
    legal_store    = 1'b0;
    req_misaligned = 1'b0;
    if (req_read && !req_write) begin
      legal_load = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) ||
                   (req_funct3 == 3'b010) || (req_funct3 == 3'b100) ||
                   (req_funct3 == 3'b101);
    end
    if (req_write && !req_read) begin
      legal_store = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) ||
                    (req_funct3 == 3'b010);
    end
    req_illegal = !(legal_load || legal_store);
    if (!req_illegal) begin
      req_misaligned = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                       ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
    end
  end

  // Select the addressed lane of the memory word and extend it for a load.
  always_comb begin
    load_byte = 8'h00;
    case (lane_q)
      2'd0: load_byte = mem_rdata[7:0];
      2'd1: load_byte = mem_rdata[15:8];
      2'd2: load_byte = mem_rdata[23:16];
      2'd3: load_byte = mem_rdata[31:24];
      default: load_byte = 8'h00;
    endcase
    load_half = lane_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (funct3_q)
      3'b000:  load_ext = {{24{load_byte[7]}}, load_byte};
      3'b001:  load_ext = {{16{load_half[15]}}, load_half};
      3'b100:  load_ext = {24'h000000, load_byte};
      3'b101:  load_ext = {16'h0000, load_half};
      default: load_ext = mem_rdata;
    endcase
  end

  // Replace only the addressed byte or halfword of the captured word.
  always_comb begin
    merged = word_q;
    if (funct3_q[1:0] == 2'b00) begin
      merged[{lane_q, 3'b000} +: 8] = wdata_q[7:0];
    end else if (funct3_q[1:0] == 2'b01) begin
      merged[{lane_q[1], 4'b0000} +: 16] = wdata_q[15:0];
    end
  end

  // Next-state and output decode for the request FSM.
  always_comb begin
    state_d         = state_q;
    widx_d          = widx_q;
    lane_d          = lane_q;
    funct3_d        = funct3_q;
    wdata_d         = wdata_q;
    write_d         = write_q;
    illegal_d       = illegal_q;
    misaligned_d    = misaligned_q;
    word_d          = word_q;
    ready_int       = 1'b0;
    mem_addr        = '0;
    mem_we          = 1'b0;
    mem_wdata       = 32'h0;
    resp_valid      = 1'b0;
    resp_rdata      = 32'h0;
    resp_misaligned = 1'b0;
    resp_illegal    = 1'b0;
    case (state_q)
      S_IDLE: begin
        ready_int = 1'b1;
        if (req_valid) begin
          widx_d       = req_addr[ADDR_WIDTH+1:2];
          lane_d       = req_addr[1:0];
          funct3_d     = req_funct3;
          wdata_d      = req_wdata;
          write_d      = req_write;
          illegal_d    = req_illegal;
          misaligned_d = req_misaligned;
          word_d       = 32'h0;
          if (req_illegal || req_misaligned) begin
            state_d = S_RESP;
          end else if (legal_load) begin
            state_d = S_LOAD;
          end else if (req_funct3[1:0] == 2'b10) begin
            state_d = S_WRITE;
          end else begin
            state_d = S_RMW_RD;
          end
        end
      end
      S_LOAD: begin
        mem_addr = widx_q;
        word_d   = load_ext;
        state_d  = S_RESP;
      end
      S_RMW_RD: begin
        mem_addr = widx_q;
        word_d   = mem_rdata;
        state_d  = S_WRITE;
      end
      S_WRITE: begin
        mem_addr  = widx_q;
        mem_we    = 1'b1;
        mem_wdata = (funct3_q[1:0] == 2'b10) ? wdata_q : merged;
        state_d   = S_RESP;
      end
      S_RESP: begin
        resp_valid      = 1'b1;
        resp_misaligned = misaligned_q;
        resp_illegal    = illegal_q;
        if (!write_q && !illegal_q && !misaligned_q) begin
          resp_rdata = word_q;
        end
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Ready is held low while reset is asserted even though the state is IDLE.
  assign req_ready = ready_int & rst;
  assign dbg_state = state_q;

  // State and request registers; reset aborts any in-flight request.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      widx_q       <= '0;
      lane_q       <= 2'd0;
      funct3_q     <= 3'd0;
      wdata_q      <= 32'h0;
      write_q      <= 1'b0;
      illegal_q    <= 1'b0;
      misaligned_q <= 1'b0;
      word_q       <= 32'h0;
    end else begin
      state_q      <= state_d;
      widx_q       <= widx_d;
      lane_q       <= lane_d;
      funct3_q     <= funct3_d;
      wdata_q      <= wdata_d;
      write_q      <= write_d;
      illegal_q    <= illegal_d;
      misaligned_q <= misaligned_d;
      word_q       <= word_d;
    end
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Memory-stage load/store controller for the pipeline core: accepts one load or store request at a time from the MEM stage, drives the word-addressed, write-enable-only data memory, and returns a response. It handles RV32I byte and halfword loads (with sign or zero extension) and byte and halfword stores. Sub-word stores are done as read-modify-write, because the memory has no byte strobes. Misaligned and illegal requests are flagged, and memory is never written for them.

## Interface
Parameters:
- ADDR_WIDTH, 10, word-index width of the data memory (1024 words)

Ports:
- clk  in  1  clock; all state updates on its rising edge
- rst  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  unit can accept a request
- req_read  in  1  load request
- req_write  in  1  store request
- req_funct3  in  3  RV32I funct3 (size and signedness)
- req_addr  in  32  byte address
- req_wdata  in  32  store data; the lowest byte or halfword is used for SB/SH
- resp_valid  out  1  one-cycle response pulse
- resp_rdata  out  32  extended load data; 0 for stores and faults
- resp_misaligned  out  1  request was misaligned
- resp_illegal  out  1  request was illegal
- mem_addr  out  ADDR_WIDTH  word index, equal to req_addr[ADDR_WIDTH+1:2] as latched
- mem_we  out  1  memory write enable
- mem_wdata  out  32  full word to write
- mem_rdata  in  32  combinational read data for mem_addr

## Operation
- States: IDLE, LOAD, RMW_RD, WRITE, RESP.
- Acceptance: a request is accepted on a rising edge while in IDLE with req_valid=1. At acceptance the unit latches addr, funct3, wdata and the read/write flags.
- req_ready: equals 1 only in IDLE. It is 0 while rst is low.
- Legal loads (req_read=1, req_write=0):
  - 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- Legal stores (req_write=1, req_read=0):
  - 000 SB, 001 SH, 010 SW.
- Illegal: any other funct3, or read and write both 1, or both 0. Result: IDLE→RESP with resp_illegal=1.
- Misaligned: LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]≠0.
  - Result: IDLE→RESP with resp_misaligned=1.
  - Illegal takes priority over misaligned; only resp_illegal is set.
- Load path: IDLE→LOAD.
  - In LOAD, mem_addr is driven and the selected byte or halfword of mem_rdata is captured, extended, and stored in a register. The selected lane is given by addr[1:0].
  - Then LOAD→RESP.
- SW path: IDLE→WRITE. In WRITE, mem_we=1 and mem_wdata=wdata. Then WRITE→RESP.
- SB/SH path: IDLE→RMW_RD→WRITE→RESP.
  - In RMW_RD, mem_rdata is captured.
  - In WRITE, the captured word is written with only the addressed lane replaced. SB uses wdata[7:0] into the byte at addr[1:0]. SH uses wdata[15:0] into the halfword at addr[1].
- RESP: resp_valid=1 for exactly one cycle, then RESP→IDLE.
- mem_we is 1 only in WRITE. mem_addr and mem_wdata may be arbitrary outside the LOAD, RMW_RD and WRITE states.
- Address bits above ADDR_WIDTH+1 are ignored, so addresses wrap modulo the memory size.
- Reset (rst low): state is forced to IDLE immediately and every output goes to 0, including req_ready. A store that has not yet reached a WRITE rising edge is aborted and writes nothing.

## Timing
- Cycle 0 is the acceptance edge.
- LW/LB/LH/LBU/LHU: LOAD in cycle 1, resp_valid in cycle 2.
- SW: WRITE in cycle 1, memory updated at the end of cycle 1, resp_valid in cycle 2.
- SB/SH: RMW_RD in cycle 1, WRITE in cycle 2, resp_valid in cycle 3.
- Faults: resp_valid in cycle 1. No memory access occurs.
- The next acceptance is possible one cycle after RESP, so back-to-back throughput is 3, 3 or 4 cycles per request.
- resp_rdata, resp_misaligned and resp_illegal are valid only while resp_valid=1, and are 0 otherwise.
- Request inputs are ignored outside IDLE.

## Test plan
- Reset: rst low mid-SW while in WRITE → mem_we drops at once, all outputs 0. After release, req_ready=1 on the next cycle.
- LW at address 0x10 with mem[4]=0x8081_F2F3 → resp_rdata=0x8081F2F3 in cycle 2. Then:
  - LB at 0x13 → 0xFFFFFF80.
  - LBU at 0x13 → 0x00000080.
  - LH at 0x12 → 0xFFFF8081.
- Store sizes on mem[4]=0x11223344:
  - SB at 0x11 with wdata=0xAABBCCDD → mem[4]=0x1122DD44, resp_valid in cycle 3.
  - SH at 0x12 with wdata=0x0000BEEF → mem[4]=0xBEEFDD44.
  - SW at 0x10 with wdata=0xCAFEBABE → mem[4]=0xCAFEBABE, resp_valid in cycle 2.
- Faults:
  - LW at 0x12 → resp_misaligned=1 in cycle 1, no memory access.
  - SH at 0x21 → resp_misaligned=1, mem_we never asserted.
  - funct3=011 load → resp_illegal=1.
  - req_read=req_write=1 → resp_illegal=1.
- Back-to-back: with req_valid held high, issue SB then LW to the same word. The LW is accepted one cycle after the SB's RESP and returns the merged value.
- Wrap: with ADDR_WIDTH=10, SW at 0x1000 with wdata=0x5 → mem_addr=0, so mem[0]=0x5.
